// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind scoreboard slice.
//
// Holds the game FSM state encoding, the width of peg/colour counts and the
// default game geometry, plus a helper that decides whether a red/white pair
// coming from the peg comparator is physically possible.
package mastermind_pkg;

    // Game state encoding; PLAYING is the reset/new-game state.
    typedef enum logic [1:0] {
        ST_PLAYING = 2'd0,
        ST_WON     = 2'd1,
        ST_LOST    = 2'd2
    } state_e;

    // Width of a peg count / colour value.
    localparam int PEG_W = 3;

    // Default game geometry.
    localparam int DEFAULT_PEGS        = 4;
    localparam int DEFAULT_MAX_GUESSES = 8;
    localparam int DEFAULT_BLINK_TICKS = 4;

    // A feedback pair is impossible if it reports more exact matches than
    // there are pegs, or more total matches than pegs. The sum is formed at
    // 4 bits so that 7 + 7 cannot wrap back into the legal range.
    function automatic logic fbInvalid(input logic [PEG_W-1:0] r,
                                       input logic [PEG_W-1:0] w,
                                       input int pegs);
        logic [3:0] sum;
        sum = {1'b0, r} + {1'b0, w};
        return ({1'b0, r} > 4'(pegs)) || (sum > 4'(pegs));
    endfunction

endpackage

// File: rtl/mastermind_blinker.sv
// Blink generator for the "won" display.
//
// While en is high, a counter runs 0..BLINK_TICKS-1 and the blink output
// inverts each time the counter wraps, so blink holds each level for
// BLINK_TICKS cycles and starts low. Dropping en clears both the counter and
// the output so the next enable starts a fresh low half-period.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   en     - run enable; low clears the generator
//   blink  - blink level
module mastermind_blinker
    import mastermind_pkg::*;
#(
    parameter int BLINK_TICKS = DEFAULT_BLINK_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic blink
);

    localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BLINK_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    // Next-state: clear when disabled, otherwise count and toggle on wrap.
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (!en) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/mastermind_scoreboard.sv
// Mastermind scoreboard: downstream stage of the peg comparator.
//
// Accepts one red/white feedback pulse per scored guess, counts guesses,
// keeps a per-guess feedback history, decides win/loss and drives the game
// status, reveal and blink signals used by the HEX/LED display logic.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   new_game            - one-cycle pulse restarting the game (any state)
//   result_valid        - one-cycle pulse, red/white valid
//   red, white          - exact-position and colour-only match counts
//   hist_sel            - history entry to read (combinational)
//   hist_red/white      - feedback stored in the selected entry
//   hist_valid          - selected entry was written this game
//   last_red/white      - most recently accepted feedback
//   guess_count         - accepted guesses this game
//   playing/win/lose    - one-hot game status
//   reveal              - game over, unblank the secret code
//   blink               - display blink enable
//   fb_err              - sticky flag for impossible feedback
module mastermind_scoreboard
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = DEFAULT_MAX_GUESSES,
    parameter int PEGS        = DEFAULT_PEGS,
    parameter int BLINK_TICKS = DEFAULT_BLINK_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_game,
    input  logic             result_valid,
    input  logic [PEG_W-1:0] red,
    input  logic [PEG_W-1:0] white,
    input  logic [2:0]       hist_sel,
    output logic [PEG_W-1:0] hist_red,
    output logic [PEG_W-1:0] hist_white,
    output logic             hist_valid,
    output logic [PEG_W-1:0] last_red,
    output logic [PEG_W-1:0] last_white,
    output logic [3:0]       guess_count,
    output logic             playing,
    output logic             win,
    output logic             lose,
    output logic             reveal,
    output logic             blink,
    output logic             fb_err
);

    localparam logic [PEG_W-1:0] PEGS_V      = PEG_W'(PEGS);
    localparam logic [3:0]       MAX_GUESS_V = 4'(MAX_GUESSES);

    state_e                 state_q, state_d;
    logic [3:0]             guess_count_q, guess_count_d;
    logic [PEG_W-1:0]       last_red_q, last_red_d;
    logic [PEG_W-1:0]       last_white_q, last_white_d;
    logic                   fb_err_q, fb_err_d;
    logic [PEG_W-1:0]       hist_red_q   [MAX_GUESSES];
    logic [PEG_W-1:0]       hist_red_d   [MAX_GUESSES];
    logic [PEG_W-1:0]       hist_white_q [MAX_GUESSES];
    logic [PEG_W-1:0]       hist_white_d [MAX_GUESSES];
    logic [MAX_GUESSES-1:0] hist_valid_q, hist_valid_d;

    logic blinker_en;
    logic blinker_out;

    // Game FSM and history update. new_game wins over a simultaneous result,
    // which is simply dropped. Once the game is decided, results are ignored,
    // so guess_count can never pass MAX_GUESSES. A winning guess is checked
    // before the out-of-guesses condition so a win on the last guess counts.
    always_comb begin
        state_d       = state_q;
        guess_count_d = guess_count_q;
        last_red_d    = last_red_q;
        last_white_d  = last_white_q;
        fb_err_d      = fb_err_q;
        hist_red_d    = hist_red_q;
        hist_white_d  = hist_white_q;
        hist_valid_d  = hist_valid_q;

        if (new_game) begin
            state_d       = ST_PLAYING;
            guess_count_d = '0;
            last_red_d    = '0;
            last_white_d  = '0;
            fb_err_d      = 1'b0;
            hist_valid_d  = '0;
        end else if ((state_q == ST_PLAYING) && result_valid) begin
            if (fbInvalid(red, white, PEGS)) begin
                fb_err_d = 1'b1;
            end else begin
                for (int i = 0; i < MAX_GUESSES; i++) begin
                    if (guess_count_q == 4'(i)) begin
                        hist_red_d[i]   = red;
                        hist_white_d[i] = white;
                        hist_valid_d[i] = 1'b1;
                    end
                end
                last_red_d    = red;
                last_white_d  = white;
                guess_count_d = guess_count_q + 4'd1;
                if (red == PEGS_V) begin
                    state_d = ST_WON;
                end else if (guess_count_d == MAX_GUESS_V) begin
                    state_d = ST_LOST;
                end
            end
        end
    end

    // State registers. History data is cleared only by reset; a new game
    // just drops the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_PLAYING;
            guess_count_q <= '0;
            last_red_q    <= '0;
            last_white_q  <= '0;
            fb_err_q      <= 1'b0;
            hist_valid_q  <= '0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
                hist_red_q[i]   <= '0;
                hist_white_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            guess_count_q <= guess_count_d;
            last_red_q    <= last_red_d;
            last_white_q  <= last_white_d;
            fb_err_q      <= fb_err_d;
            hist_valid_q  <= hist_valid_d;
            hist_red_q    <= hist_red_d;
            hist_white_q  <= hist_white_d;
        end
    end

    // History read port. An out-of-range index simply never matches, so it
    // reads back as an empty entry.
    always_comb begin
        hist_red   = '0;
        hist_white = '0;
        hist_valid = 1'b0;
        for (int i = 0; i < MAX_GUESSES; i++) begin
            if ((hist_sel == 3'(i)) && hist_valid_q[i]) begin
                hist_red   = hist_red_q[i];
                hist_white = hist_white_q[i];
                hist_valid = 1'b1;
            end
        end
    end

    // The blinker runs only while sitting in WON. Suppressing it on a
    // new_game edge makes sure it restarts from a clean low phase.
    assign blinker_en = (state_q == ST_WON) && !new_game;

    mastermind_blinker #(
        .BLINK_TICKS (BLINK_TICKS)
    ) u_blinker (
        .clk   (clk),
        .reset (reset),
        .en    (blinker_en),
        .blink (blinker_out)
    );

    // Status outputs: blink is steady on after a loss, pulsing after a win.
    assign playing     = (state_q == ST_PLAYING);
    assign win         = (state_q == ST_WON);
    assign lose        = (state_q == ST_LOST);
    assign reveal      = win | lose;
    assign blink       = win ? blinker_out : lose;
    assign guess_count = guess_count_q;
    assign last_red    = last_red_q;
    assign last_white  = last_white_q;
    assign fb_err      = fb_err_q;

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// Testbench for mastermind_scoreboard.
//
// A game-level model tracks the status, guess list and blink timing from the
// game rules; every cycle the DUT outputs are compared against it. Directed
// game scenarios with literal expectations come first, then a long run of
// randomized feedback, new-game and reset pulses.
module tb_mastermind_scoreboard;

    localparam int MAXG = 8;
    localparam int PEGS = 4;
    localparam int BT   = 4;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic       result_valid;
    logic [2:0] red;
    logic [2:0] white;
    logic [2:0] hist_sel;
    logic [2:0] hist_red;
    logic [2:0] hist_white;
    logic       hist_valid;
    logic [2:0] last_red;
    logic [2:0] last_white;
    logic [3:0] guess_count;
    logic       playing;
    logic       win;
    logic       lose;
    logic       reveal;
    logic       blink;
    logic       fb_err;

    int assertCount = 0;
    int failCount   = 0;

    // Game model: 0 = playing, 1 = won, 2 = lost.
    int mState;
    int mCount;
    int mLastR;
    int mLastW;
    int mErr;
    int mWonCycles;
    int mHR [MAXG];
    int mHW [MAXG];
    int mHV [MAXG];

    mastermind_scoreboard #(
        .MAX_GUESSES (MAXG),
        .PEGS        (PEGS),
        .BLINK_TICKS (BT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .result_valid (result_valid),
        .red          (red),
        .white        (white),
        .hist_sel     (hist_sel),
        .hist_red     (hist_red),
        .hist_white   (hist_white),
        .hist_valid   (hist_valid),
        .last_red     (last_red),
        .last_white   (last_white),
        .guess_count  (guess_count),
        .playing      (playing),
        .win          (win),
        .lose         (lose),
        .reveal       (reveal),
        .blink        (blink),
        .fb_err       (fb_err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at a negedge and wait for the next negedge.
    task automatic applyStimulus(input bit rs, input bit ng, input bit rv, input int r, input int w);
        reset        = rs;
        new_game     = ng;
        result_valid = rv;
        red          = 3'(r);
        white        = 3'(w);
        hist_sel     = 3'($urandom_range(0, 7));
        @(negedge clk);
    endtask

    // Read one history entry and compare it with literal values.
    task automatic checkHist(input int sel, input int er, input int ew, input int ev);
        hist_sel = 3'(sel);
        #1;
        checkOutput($sformatf("hist_red[%0d]", sel), 32'(hist_red), 32'(er));
        checkOutput($sformatf("hist_white[%0d]", sel), 32'(hist_white), 32'(ew));
        checkOutput($sformatf("hist_valid[%0d]", sel), 32'(hist_valid), 32'(ev));
    endtask

    // Model update from the game rules at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            mState = 0; mCount = 0; mLastR = 0; mLastW = 0; mErr = 0; mWonCycles = 0;
            for (int i = 0; i < MAXG; i++) begin
                mHR[i] = 0; mHW[i] = 0; mHV[i] = 0;
            end
        end else if (new_game) begin
            mState = 0; mCount = 0; mLastR = 0; mLastW = 0; mErr = 0; mWonCycles = 0;
            for (int i = 0; i < MAXG; i++) mHV[i] = 0;
        end else begin
            if (mState == 1) mWonCycles++;
            if (mState == 0 && result_valid) begin
                if (int'(red) > PEGS || int'(red) + int'(white) > PEGS) begin
                    mErr = 1;
                end else begin
                    mHR[mCount] = int'(red);
                    mHW[mCount] = int'(white);
                    mHV[mCount] = 1;
                    mLastR = int'(red);
                    mLastW = int'(white);
                    mCount++;
                    if (int'(red) == PEGS) begin
                        mState = 1;
                        mWonCycles = 0;
                    end else if (mCount == MAXG) begin
                        mState = 2;
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model shortly after each edge.
    always begin
        int eb, er, ew, ev, s;
        @(posedge clk);
        #1;
        eb = (mState == 0) ? 0 : (mState == 2) ? 1 : ((mWonCycles / BT) % 2);
        s  = int'(hist_sel);
        er = 0; ew = 0; ev = 0;
        if (s < MAXG && mHV[s] == 1) begin
            er = mHR[s]; ew = mHW[s]; ev = 1;
        end
        checkOutput("guess_count", 32'(guess_count), 32'(mCount));
        checkOutput("playing", 32'(playing), 32'(mState == 0));
        checkOutput("win", 32'(win), 32'(mState == 1));
        checkOutput("lose", 32'(lose), 32'(mState == 2));
        checkOutput("reveal", 32'(reveal), 32'(mState != 0));
        checkOutput("blink", 32'(blink), 32'(eb));
        checkOutput("fb_err", 32'(fb_err), 32'(mErr));
        checkOutput("last_red", 32'(last_red), 32'(mLastR));
        checkOutput("last_white", 32'(last_white), 32'(mLastW));
        checkOutput("hist_red", 32'(hist_red), 32'(er));
        checkOutput("hist_white", 32'(hist_white), 32'(ew));
        checkOutput("hist_valid", 32'(hist_valid), 32'(ev));
    end

    initial begin
        reset        = 1'b1;
        new_game     = 1'b0;
        result_valid = 1'b0;
        red          = '0;
        white        = '0;
        hist_sel     = '0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0);

        // Reset state.
        checkOutput("rst guess_count", 32'(guess_count), 32'd0);
        checkOutput("rst playing", 32'(playing), 32'd1);
        checkOutput("rst win", 32'(win), 32'd0);
        checkOutput("rst blink", 32'(blink), 32'd0);
        checkOutput("rst fb_err", 32'(fb_err), 32'd0);

        // Win after three back-to-back guesses.
        applyStimulus(0, 0, 1, 1, 2);
        applyStimulus(0, 0, 1, 2, 1);
        applyStimulus(0, 0, 1, 4, 0);
        checkOutput("win guess_count", 32'(guess_count), 32'd3);
        checkOutput("win win", 32'(win), 32'd1);
        checkOutput("win reveal", 32'(reveal), 32'd1);
        checkOutput("win playing", 32'(playing), 32'd0);
        checkOutput("win last_red", 32'(last_red), 32'd4);
        checkHist(2, 4, 0, 1);
        checkHist(0, 1, 2, 1);

        // Blink pattern after entering WON: 4 low, 4 high, 4 low, then high.
        checkOutput("blink k0", 32'(blink), 32'd0);
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("blink k%0d", k), 32'(blink), 32'(((k >= 4 && k < 8) || k >= 12) ? 1 : 0));
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst-blink blink", 32'(blink), 32'd0);
        checkOutput("rst-blink win", 32'(win), 32'd0);
        checkOutput("rst-blink playing", 32'(playing), 32'd1);

        // Loss after eight guesses; a further result is ignored.
        applyStimulus(0, 1, 0, 0, 0);
        for (int g = 0; g < 8; g++) applyStimulus(0, 0, 1, 1, 1);
        checkOutput("loss lose", 32'(lose), 32'd1);
        checkOutput("loss blink", 32'(blink), 32'd1);
        checkOutput("loss guess_count", 32'(guess_count), 32'd8);
        applyStimulus(0, 0, 1, 4, 0);
        checkOutput("loss9 win", 32'(win), 32'd0);
        checkOutput("loss9 guess_count", 32'(guess_count), 32'd8);
        checkOutput("loss9 last_red", 32'(last_red), 32'd1);

        // Win on the final guess.
        applyStimulus(0, 1, 0, 0, 0);
        for (int g = 0; g < 7; g++) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 4, 0);
        checkOutput("final win", 32'(win), 32'd1);
        checkOutput("final lose", 32'(lose), 32'd0);
        checkOutput("final guess_count", 32'(guess_count), 32'd8);

        // Impossible feedback is flagged and not counted.
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 2);
        checkOutput("inv fb_err", 32'(fb_err), 32'd1);
        checkOutput("inv guess_count", 32'(guess_count), 32'd0);
        checkHist(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 0);
        checkOutput("inv2 guess_count", 32'(guess_count), 32'd1);
        checkOutput("inv2 fb_err", 32'(fb_err), 32'd1);
        checkHist(0, 2, 0, 1);

        // new_game and result_valid together: result dropped.
        applyStimulus(0, 1, 0, 0, 0);
        for (int g = 0; g < 5; g++) applyStimulus(0, 0, 1, 1, 0);
        checkOutput("ng guess_count5", 32'(guess_count), 32'd5);
        applyStimulus(0, 1, 1, 4, 0);
        checkOutput("ng guess_count", 32'(guess_count), 32'd0);
        checkOutput("ng last_red", 32'(last_red), 32'd0);
        checkOutput("ng playing", 32'(playing), 32'd1);
        checkOutput("ng win", 32'(win), 32'd0);
        for (int s = 0; s < MAXG; s++) checkHist(s, 0, 0, 0);

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            int r, w;
            bit rs, ng, rv;
            rs = ($urandom_range(0, 299) == 0);
            ng = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 7);
                w = $urandom_range(0, 7);
            end else begin
                r = $urandom_range(0, 4);
                w = $urandom_range(0, 4 - r);
            end
            applyStimulus(rs, ng, rv, r, w);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
